// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the ALU execution unit: op-code encodings, FSM state
// encoding and small op-classification helpers.
package alu_exec_unit_pkg;

  localparam int ALU_OP_W = 6;

  // Base RV32I ops
  localparam logic [ALU_OP_W-1:0] OP_NONE   = 6'd0;
  localparam logic [ALU_OP_W-1:0] OP_LUI    = 6'd1;
  localparam logic [ALU_OP_W-1:0] OP_AUIPC  = 6'd2;
  localparam logic [ALU_OP_W-1:0] OP_JAL    = 6'd3;
  localparam logic [ALU_OP_W-1:0] OP_BEQ    = 6'd4;
  localparam logic [ALU_OP_W-1:0] OP_BNE    = 6'd5;
  localparam logic [ALU_OP_W-1:0] OP_BLT    = 6'd6;
  localparam logic [ALU_OP_W-1:0] OP_BGE    = 6'd7;
  localparam logic [ALU_OP_W-1:0] OP_BLTU   = 6'd8;
  localparam logic [ALU_OP_W-1:0] OP_BGEU   = 6'd9;
  localparam logic [ALU_OP_W-1:0] OP_ADD    = 6'd10;
  localparam logic [ALU_OP_W-1:0] OP_ADDI   = 6'd11;
  localparam logic [ALU_OP_W-1:0] OP_SUB    = 6'd12;
  localparam logic [ALU_OP_W-1:0] OP_AND    = 6'd13;
  localparam logic [ALU_OP_W-1:0] OP_ANDI   = 6'd14;
  localparam logic [ALU_OP_W-1:0] OP_OR     = 6'd15;
  localparam logic [ALU_OP_W-1:0] OP_ORI    = 6'd16;
  localparam logic [ALU_OP_W-1:0] OP_XOR    = 6'd17;
  localparam logic [ALU_OP_W-1:0] OP_XORI   = 6'd18;
  localparam logic [ALU_OP_W-1:0] OP_SLL    = 6'd19;
  localparam logic [ALU_OP_W-1:0] OP_SLLI   = 6'd20;
  localparam logic [ALU_OP_W-1:0] OP_SRL    = 6'd21;
  localparam logic [ALU_OP_W-1:0] OP_SRLI   = 6'd22;
  localparam logic [ALU_OP_W-1:0] OP_SRA    = 6'd23;
  localparam logic [ALU_OP_W-1:0] OP_SRAI   = 6'd24;
  localparam logic [ALU_OP_W-1:0] OP_SLT    = 6'd25;
  localparam logic [ALU_OP_W-1:0] OP_SLTI   = 6'd26;
  localparam logic [ALU_OP_W-1:0] OP_SLTU   = 6'd27;
  localparam logic [ALU_OP_W-1:0] OP_SLTIU  = 6'd28;
  // RV32M ops
  localparam logic [ALU_OP_W-1:0] OP_MUL    = 6'd29;
  localparam logic [ALU_OP_W-1:0] OP_MULH   = 6'd30;
  localparam logic [ALU_OP_W-1:0] OP_MULHSU = 6'd31;
  localparam logic [ALU_OP_W-1:0] OP_MULHU  = 6'd32;
  localparam logic [ALU_OP_W-1:0] OP_DIV    = 6'd33;
  localparam logic [ALU_OP_W-1:0] OP_DIVU   = 6'd34;
  localparam logic [ALU_OP_W-1:0] OP_REM    = 6'd35;
  localparam logic [ALU_OP_W-1:0] OP_REMU   = 6'd36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per enabled cycle on operand
// magnitudes, sign fix-up applied on the outputs. done_o is raised once all
// XLEN bits are produced; the divider returns idle on the next enabled edge.
module alu_div_iter
  #(parameter int XLEN = 32)
  (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
  );

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  logic            a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN:0]   trial_s;

  // Operand magnitudes and the trial subtraction for the current bit
  always_comb begin
    a_neg_s = signed_i & dividend_i[XLEN-1];
    b_neg_s = signed_i & divisor_i[XLEN-1];
    a_mag_s = a_neg_s ? (XLEN'(0) - dividend_i) : dividend_i;
    b_mag_s = b_neg_s ? (XLEN'(0) - divisor_i) : divisor_i;
    trial_s = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
  end

  // Next-state: load on start, shift-subtract while counting, idle after done
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (en_i) begin
      if (clear_i) begin
        busy_d = 1'b0;
        cnt_d  = {CNT_W{1'b0}};
      end else if (start_i) begin
        busy_d    = 1'b1;
        cnt_d     = CNT_W'(XLEN);
        quo_d     = a_mag_s;
        rem_d     = {XLEN{1'b0}};
        dsr_d     = b_mag_s;
        neg_quo_d = a_neg_s ^ b_neg_s;
        neg_rem_d = a_neg_s;
      end else if (busy_q) begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!trial_s[XLEN]) begin
            rem_d = trial_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          busy_d = 1'b0;
        end
      end else begin
        busy_d = 1'b0;
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      dsr_q     <= {XLEN{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == {CNT_W{1'b0}});
  assign quotient_o  = neg_quo_q ? (XLEN'(0) - quo_q) : quo_q;
  assign remainder_o = neg_rem_q ? (XLEN'(0) - rem_q) : rem_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: RV32I base ops in one cycle, inline fixed-latency
// multiply, iterative divide. One op in flight; the result is held with its
// ROB tag until the CDB accepts it.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
  #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 4,
    parameter int MUL_CYCLES = 2,
    parameter int OP_W       = ALU_OP_W
  )
  (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
  );

  localparam int SHW   = $clog2(XLEN);
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e          state_q, state_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fast_q, fast_d;
  logic [XLEN-1:0]     fast_res_q, fast_res_d;

  logic [ALU_OP_W-1:0] in_op_s;
  logic                accept_s;
  logic [SHW-1:0]      shamt_s;
  logic [XLEN-1:0]     base_res_s;
  logic                div_zero_s, div_ovf_s, div_fast_s;
  logic [XLEN-1:0]     div_fast_res_s;
  logic                div_start_s, div_busy_s, div_done_s;
  logic [XLEN-1:0]     div_quo_s, div_rem_s;
  logic                mul_sa_s, mul_sb_s;
  logic [2*XLEN-1:0]   mul_a_ext_s, mul_b_ext_s, mul_prod_s;
  logic [XLEN-1:0]     mul_res_s;

  assign in_op_s  = ALU_OP_W'(in_op);
  assign in_ready = (state_q == ST_IDLE);
  assign accept_s = in_valid && (state_q == ST_IDLE) && rdy_in && !flush_in &&
                    (in_op_s != OP_NONE);
  assign shamt_s  = in_b[SHW-1:0];

  // Single-cycle base-op result straight from the dispatch operands
  always_comb begin
    base_res_s = {XLEN{1'b0}};
    case (in_op_s)
      OP_LUI:             base_res_s = in_a;
      OP_AUIPC:           base_res_s = in_a + in_b;
      OP_JAL:             base_res_s = in_b + XLEN'(4);
      OP_BEQ:             base_res_s = XLEN'(in_a == in_b);
      OP_BNE:             base_res_s = XLEN'(in_a != in_b);
      OP_BLT, OP_SLT, OP_SLTI:
                          base_res_s = XLEN'($signed(in_a) < $signed(in_b));
      OP_BGE:             base_res_s = XLEN'($signed(in_a) >= $signed(in_b));
      OP_BLTU, OP_SLTU, OP_SLTIU:
                          base_res_s = XLEN'(in_a < in_b);
      OP_BGEU:            base_res_s = XLEN'(in_a >= in_b);
      OP_ADD, OP_ADDI:    base_res_s = in_a + in_b;
      OP_SUB:             base_res_s = in_a - in_b;
      OP_AND, OP_ANDI:    base_res_s = in_a & in_b;
      OP_OR, OP_ORI:      base_res_s = in_a | in_b;
      OP_XOR, OP_XORI:    base_res_s = in_a ^ in_b;
      OP_SLL, OP_SLLI:    base_res_s = in_a << shamt_s;
      OP_SRL, OP_SRLI:    base_res_s = in_a >> shamt_s;
      OP_SRA, OP_SRAI:    base_res_s = $signed(in_a) >>> shamt_s;
      default:            base_res_s = {XLEN{1'b0}};
    endcase
  end

  // Divide special cases resolved at dispatch so the DIV state can bypass the loop
  always_comb begin
    div_zero_s = (in_b == {XLEN{1'b0}});
    div_ovf_s  = is_signed_div_op(in_op_s) && (in_a == MIN_VAL) && (in_b == {XLEN{1'b1}});
    div_fast_s = div_zero_s || div_ovf_s;
    if (is_rem_op(in_op_s)) begin
      div_fast_res_s = div_zero_s ? in_a : {XLEN{1'b0}};
    end else begin
      div_fast_res_s = div_zero_s ? {XLEN{1'b1}} : MIN_VAL;
    end
  end

  // Full-width product from latched operands, sign-extended per op
  always_comb begin
    mul_sa_s    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    mul_sb_s    = (op_q == OP_MULH);
    mul_a_ext_s = {{XLEN{mul_sa_s & a_q[XLEN-1]}}, a_q};
    mul_b_ext_s = {{XLEN{mul_sb_s & b_q[XLEN-1]}}, b_q};
    mul_prod_s  = mul_a_ext_s * mul_b_ext_s;
    if (op_q == OP_MUL) begin
      mul_res_s = mul_prod_s[XLEN-1:0];
    end else begin
      mul_res_s = mul_prod_s[2*XLEN-1:XLEN];
    end
  end

  assign div_start_s = accept_s && is_div_op(in_op_s) && !div_fast_s;

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .en_i        (rdy_in),
    .clear_i     (flush_in),
    .start_i     (div_start_s),
    .signed_i    (is_signed_div_op(in_op_s)),
    .dividend_i  (in_a),
    .divisor_i   (in_b),
    .busy_o      (div_busy_s),
    .done_o      (div_done_s),
    .quotient_o  (div_quo_s),
    .remainder_o (div_rem_s)
  );

  // FSM next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    fast_d      = fast_q;
    fast_res_d  = fast_res_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
        fast_d      = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_s) begin
              op_d  = in_op_s;
              a_d   = in_a;
              b_d   = in_b;
              tag_d = in_tag;
              if (is_mul_op(in_op_s)) begin
                state_d = ST_MUL;
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
              end else if (is_div_op(in_op_s)) begin
                state_d    = ST_DIV;
                fast_d     = div_fast_s;
                fast_res_d = div_fast_res_s;
              end else begin
                state_d     = ST_DONE;
                result_d    = base_res_s;
                out_valid_d = 1'b1;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_MUL: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
              state_d     = ST_DONE;
              result_d    = mul_res_s;
              out_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          ST_DIV: begin
            if (fast_q) begin
              state_d     = ST_DONE;
              result_d    = fast_res_q;
              out_valid_d = 1'b1;
              fast_d      = 1'b0;
            end else if (div_done_s) begin
              state_d     = ST_DONE;
              result_d    = is_rem_op(op_q) ? div_rem_s : div_quo_s;
              out_valid_d = 1'b1;
            end else if (!div_busy_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DIV;
            end
          end
          ST_DONE: begin
            if (out_ready) begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
            end else begin
              state_d = ST_DONE;
            end
          end
          default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and result registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      a_q         <= {XLEN{1'b0}};
      b_q         <= {XLEN{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      result_q    <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      fast_q      <= 1'b0;
      fast_res_q  <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      fast_q      <= fast_d;
      fast_res_q  <= fast_res_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised + directed bench for alu_exec_unit against a plain-arithmetic
// reference model of the RV32IM results and the documented latencies.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 4;
  localparam int MUL_CYCLES = 2;

  logic             clk = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             flush_in;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_fails  = 0;

  alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_CYCLES(MUL_CYCLES), .OP_W(6)) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results from the ISA definitions
  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] p;
    int unsigned sh;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op)
      OP_LUI:                     return a;
      OP_AUIPC:                   return a + b;
      OP_JAL:                     return b + 32'd4;
      OP_BEQ:                     return (a == b) ? 32'd1 : 32'd0;
      OP_BNE:                     return (a != b) ? 32'd1 : 32'd0;
      OP_BLT, OP_SLT, OP_SLTI:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_BGE:                     return (sa >= sb) ? 32'd1 : 32'd0;
      OP_BLTU, OP_SLTU, OP_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      OP_BGEU:                    return (a >= b) ? 32'd1 : 32'd0;
      OP_ADD, OP_ADDI:            return a + b;
      OP_SUB:                     return a - b;
      OP_AND, OP_ANDI:            return a & b;
      OP_OR, OP_ORI:              return a | b;
      OP_XOR, OP_XORI:            return a ^ b;
      OP_SLL, OP_SLLI:            return a << sh;
      OP_SRL, OP_SRLI:            return a >> sh;
      OP_SRA, OP_SRAI:            return 32'(sa >>> sh);
      OP_MUL:    begin p = 64'(a) * 64'(b); return p[31:0]; end
      OP_MULH:   begin sp = longint'(sa) * longint'(sb); p = sp; return p[63:32]; end
      OP_MULHSU: begin sp = longint'(sa) * longint'({32'd0, b}); p = sp; return p[63:32]; end
      OP_MULHU:  begin p = 64'(a) * 64'(b); return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      OP_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Accept-to-out_valid latency in cycles with rdy_in held high
  function automatic int ref_latency(input logic [5:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return MUL_CYCLES + 1;
    if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
      if (b == 32'd0) return 2;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return XLEN + 2;
    end
    return 1;
  endfunction

  // Dispatch one op, wait for its result, check it, then retire it
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input int stall_at,
                        input int stall_len, input int hold);
    int w;
    int lat;
    int exp_lat;
    logic stalled;
    logic [31:0] exp_res;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b) + stall_len;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    check({name, "_ready_wait"}, 64'(w < 50), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_tag   = 4'($urandom);
    check({name, "_busy"}, 64'(in_ready), 64'd0);
    lat = 1;
    stalled = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (!stalled && stall_len > 0 && lat == stall_at) begin
        stalled = 1'b1;
        rdy_in = 1'b0;
        repeat (stall_len) begin
          step();
          lat++;
        end
        rdy_in = 1'b1;
      end else begin
        step();
        lat++;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, 64'(out_result), 64'(exp_res));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    repeat (hold) begin
      step();
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_result"}, 64'(out_result), 64'(exp_res));
      check({name, "_hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_retired"}, 64'(out_valid), 64'd0);
    check({name, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [5:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int base;
    int s_at;
    int s_len;
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    flush_in  = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_NONE;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_tag    = 4'd0;
    out_ready = 1'b0;
    repeat (3) step();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(out_result), 64'd0);
    check("reset_tag", 64'(out_tag), 64'd0);
    rst_in = 1'b1;
    step();
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a divide
    in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd100; in_b = 32'd7; in_tag = 4'd5;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_in = 1'b0;
    #2;
    check("rst_mid_div_valid", 64'(out_valid), 64'd0);
    step();
    rst_in = 1'b1;
    step();
    check("rst_mid_div_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    check("rst_mid_div_no_output", 64'(seen), 64'd0);

    // Directed cases
    run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3, 0, 0, 4);
    run_op("sra_mask", OP_SRA, 32'h8000_0000, 32'h0000_0021, 4'd1, 0, 0, 0);
    run_op("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 4'd2, 0, 0, 0);
    run_op("sll", OP_SLL, 32'h0000_0003, 32'h0000_003F, 4'd4, 0, 0, 0);
    run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 4'd6, 0, 0, 1);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 0, 0, 0);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd8, 0, 0, 0);
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 4'd9, 0, 0, 0);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 4'd10, 0, 0, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 0, 0, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 0, 0, 0);
    run_op("mul_stall", OP_MUL, 32'd12345, 32'd678, 4'd13, 1, 3, 0);
    run_op("div_stall", OP_DIVU, 32'd1000, 32'd7, 4'd14, 5, 3, 0);

    // Flush at DIV cycle 10 with a concurrent dispatch
    in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd100; in_b = 32'd7; in_tag = 4'd1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush_in = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd1; in_b = 32'd2; in_tag = 4'd2;
    step();
    flush_in = 1'b0;
    in_valid = 1'b0;
    check("flush_div_valid", 64'(out_valid), 64'd0);
    check("flush_div_idle", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    check("flush_div_no_output", 64'(seen), 64'd0);

    // op none is never accepted
    in_valid = 1'b1; in_op = OP_NONE;
    step();
    in_valid = 1'b0;
    check("op_none_ready", 64'(in_ready), 64'd1);
    check("op_none_valid", 64'(out_valid), 64'd0);

    // Flush in DONE beats out_ready; rdy_in low freezes DONE
    in_valid = 1'b1; in_op = OP_XOR; in_a = 32'hA5A5_0000; in_b = 32'h0F0F_0F0F; in_tag = 4'd15;
    step();
    in_valid = 1'b0;
    check("done_valid", 64'(out_valid), 64'd1);
    rdy_in = 1'b0; out_ready = 1'b1;
    step();
    check("stall_done_valid", 64'(out_valid), 64'd1);
    check("stall_done_result", 64'(out_result), 64'hAAAA_0F0F);
    rdy_in = 1'b1; flush_in = 1'b1;
    step();
    flush_in = 1'b0; out_ready = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_idle", 64'(in_ready), 64'd1);

    // Randomised ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 6'($urandom_range(1, 36));
      ra  = rand_operand();
      rb  = rand_operand();
      base = ref_latency(rop, ra, rb);
      s_at = 0;
      s_len = 0;
      if (base > 1 && $urandom_range(0, 3) == 0) begin
        s_at  = $urandom_range(1, base - 1);
        s_len = $urandom_range(1, 4);
      end
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 4'($urandom), s_at, s_len,
             $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execution unit behind the ALU reservation station: base RV32I ALU ops plus RV32M multiply/divide, with one operation in flight.
- Accepts a dispatched op over a valid/ready handshake and holds the registered result with its ROB tag until the CDB arbiter accepts it.
- Honours rdy_in stall and ROB flush.

Parameters:
- XLEN, 32, operand/result width (power of two, ≥8).
- TAG_W, 4, ROB tag width.
- MUL_CYCLES, 2, fixed multiply latency in cycles, ≥1.
- OP_W, 6, op-code width (matches shared op constants).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; low = hold all state, no handshakes complete.
- flush_in  input  1  mispredict flush; aborts in-flight op next edge.
- in_valid  input  1  dispatch request.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  OP_W  operation code.
- in_a  input  XLEN  operand A (rs1 or immediate per op).
- in_b  input  XLEN  operand B (rs2, immediate or pc per op).
- in_tag  input  TAG_W  ROB tag.
- out_valid  output  1  result held.
- out_ready  input  1  CDB accepted.
- out_result  output  XLEN  result.
- out_tag  output  TAG_W  tag of result.

Behaviour:
- Reset (rst_in low, async): state IDLE; out_valid=0, out_result=0, out_tag=0; in_ready=1 after release.
- States: IDLE, MUL, DIV, DONE.
- IDLE: accept when in_valid && in_ready && rdy_in && !flush_in; latch op/operands/tag.
  - Base op -> DONE next edge (latency 1).
  - Mul* -> MUL; Div*/Rem* -> DIV.
  - op==0 (none) is ignored and not accepted.
- Base ops:
  - Lui=a; Auipc=a+b; Jal=b+4.
  - Branches/Slt*: 1 or 0, signed/unsigned as named.
  - Add/Addi, Sub, And, Or, Xor (and imm forms).
  - Shifts use only b[log2(XLEN)-1:0]; Sra/Srai arithmetic; Sll is a logical left shift.
  - All arithmetic is modulo 2^XLEN.
- MUL: down-counter loaded with MUL_CYCLES-1 on entry; DONE when counter reaches 0 (accept-to-out_valid = MUL_CYCLES+1 cycles).
  - Mul = low XLEN bits; Mulh s×s, Mulhsu s×u, Mulhu u×u = high XLEN bits of the 2·XLEN product.
- DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle, XLEN iterations, then sign fix-up; DONE after XLEN+1 cycles in DIV (accept-to-out_valid = XLEN+2).
  - Divide by zero: quotient all-ones, remainder = a; takes the fast path, DONE next edge.
  - Signed overflow (a=MIN, b=-1): quotient MIN, remainder 0; fast path.
  - Remainder sign follows the dividend.
- DONE: out_valid=1, out_result/out_tag stable.
  - out_ready && rdy_in: -> IDLE, out_valid=0 next edge.
  - No same-cycle re-accept: in_ready is low in DONE.
- flush_in high (rdy_in high) in any state: -> IDLE next edge, out_valid=0, counters cleared; a dispatch in the same cycle is dropped.
- flush_in wins over out_ready.
- rdy_in low: all registers hold (including counters and the divider datapath); outputs unchanged.
- Reset mid-MUL/DIV: immediate abort to IDLE, no output.

Decomposition:
- Shared const package: op encodings (existing base ops plus new Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu), state encoding, OP_W.
- Sub-module alu_div_iter: iterative divider with start/busy/done, held by enable; reused later by a dedicated M unit.
- Multiply stays inline.

Test Plan:
- Reset mid-DIV (accept Div 100/7, assert rst_in low at cycle 5) -> out_valid stays 0, in_ready=1 after release.
- Add a=0xFFFFFFFF b=1, tag 3 -> next cycle out_valid=1, result 0, tag 3; hold out_ready=0 for 4 cycles -> result stable, in_ready=0.
- Sra a=0x80000000 b=0x00000021 -> 0xC0000000 (shift by 1 only); Sltu a=1 b=0xFFFFFFFF -> 1.
- Mulh a=0x80000000 b=0x80000000 -> 0x40000000 exactly MUL_CYCLES+1 cycles after accept; Mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- Div a=-7 b=2 -> -3 at XLEN+2 cycles; Rem -> -1; Divu a=5 b=0 -> 0xFFFFFFFF next+1 cycle; Div MIN/-1 -> 0x80000000.
- Flush at DIV cycle 10 with concurrent in_valid -> no out_valid, IDLE next edge, dispatch dropped; rdy_in low for 3 cycles mid-MUL -> latency extends by 3, correct result.
